// File: rtl/fp_ci_master.sv
// Initiator for the multi-cycle custom-instruction handshake. It takes operand pairs over
// valid/ready, issues them to one slave, and returns the result with its latency.
module fp_ci_master #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 16,
  parameter logic [31:0] TIMEOUT_RESULT = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_dataa,
  input  logic [31:0]      in_datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [CNT_W-1:0] out_cycles,
  input  logic             stall,
  output logic             ci_clk_en,
  output logic             ci_start,
  output logic [31:0]      ci_dataa,
  output logic [31:0]      ci_datab,
  input  logic             ci_done,
  input  logic [31:0]      ci_result,
  output logic             timeout_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lat, lat_nxt;
  logic             accept, cap_done, cap_to;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  assign ci_clk_en = ~stall;
  assign in_ready  = (state == IDLE) & ~reset;
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    accept    = 1'b0;
    cap_done  = 1'b0;
    cap_to    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // A done already present while start is being sampled counts as zero latency.
        if (!stall) begin
          if (ci_done) begin
            cap_done  = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!stall) begin
          lat_nxt = sat_inc(lat);
          if (ci_done) begin
            cap_done  = 1'b1;
            state_nxt = HOLD;
          end else if (lat_nxt >= TO_CNT) begin
            cap_to    = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ci_start    <= 1'b0;
      ci_dataa    <= '0;
      ci_datab    <= '0;
      lat         <= '0;
      out_result  <= '0;
      out_cycles  <= '0;
      op_count    <= '0;
      timeout_err <= 1'b0;
    end else begin
      ci_start <= (state_nxt == ISSUE);
      if (accept) begin
        ci_dataa <= in_dataa;
        ci_datab <= in_datab;
        lat      <= '0;
      end else begin
        lat <= lat_nxt;
      end
      if (cap_done) begin
        out_result <= ci_result;
        out_cycles <= lat_nxt;
        op_count   <= op_count + ONE;
      end
      if (cap_to) begin
        out_result  <= TIMEOUT_RESULT;
        out_cycles  <= TO_CNT;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fp_ci_master.md
# fp_ci_master

Initiator side of the Nios II multi-cycle custom-instruction handshake used by the PE-group FP instructions (e.g. the FP adder). Takes operand pairs from the convolution datapath over valid/ready and issues each pair to one attached custom-instruction slave: `ci_start` pulse with operands, wait for `ci_done`, capture result. Presents the result downstream over valid/ready, with a measured latency, a completion counter and a watchdog timeout. This lets PE groups be driven by hardware sequencers without a Nios core in the loop.

## Interface
- `TIMEOUT_CYCLES`, 255: enabled cycles to wait for `ci_done` before aborting (1..65535).
- `CNT_W`, 16: width of `out_cycles` and `op_count`.
- `TIMEOUT_RESULT`, 32'h7FC00000: result substituted on timeout (quiet NaN).
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair.
- `in_dataa` / `in_datab`  in  32  operands, IEEE-754 single.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_result`  out  32  captured slave result.
- `out_cycles`  out  CNT_W  measured latency of that operation.
- `stall`  in  1  global freeze request; drives `ci_clk_en` low.
- `ci_clk_en`  out  1  `~stall`, combinational.
- `ci_start`  out  1  custom-instruction start, registered.
- `ci_dataa` / `ci_datab`  out  32  operands to slave, registered, held from accept until next accept.
- `ci_done`  in  1  slave completion.
- `ci_result`  in  32  slave result, valid with `ci_done`.
- `timeout_err`  out  1  sticky; set on any timeout, cleared only by reset.
- `op_count`  out  CNT_W  completed non-timeout operations, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: `in_ready = 1`. On `in_valid & in_ready`, register operands into `ci_dataa/ci_datab`, clear latency counter, go to ISSUE.
- ISSUE: `ci_start = 1`. Slave samples start only when `ci_clk_en = 1`. If `stall`, stay in ISSUE with start held. Otherwise go to WAIT next edge; if `ci_done` is already high this cycle, capture with latency 0 and go to HOLD.
- WAIT: `ci_start = 0`. Each edge with `ci_clk_en = 1`: latency counter +1, then check.
  - If `ci_done`: capture `ci_result` to `out_result`, counter to `out_cycles`, `op_count`+1, go to HOLD.
  - Else if counter reaches `TIMEOUT_CYCLES`: `out_result = TIMEOUT_RESULT`, `out_cycles = TIMEOUT_CYCLES`, set `timeout_err`, go to HOLD; `op_count` unchanged.
  - Edges with `stall` high freeze counter and ignore `ci_done`.
- HOLD: `out_valid = 1`, outputs stable. On `out_ready` go to IDLE.
- `ci_done` in IDLE or HOLD is ignored. No state or counter change.
- Latency counter saturates at 2^CNT_W−1.
- Captured result is bit-exact; no arithmetic performed.

## Timing
- Reset values:
  - state IDLE; `ci_start` 0; `ci_dataa/ci_datab` 0.
  - `out_valid` 0; `out_result` 0; `out_cycles` 0; `op_count` 0; `timeout_err` 0.
  - `in_ready` forced 0 while `reset` high, 1 the first cycle after.
- Reset mid-operation (any state): next edge is IDLE and `ci_start` is 0. A pending `out_valid` is dropped. A late `ci_done` is ignored.
- Issue latency: accept edge N, then `ci_start` high in cycle N+1 (exactly one cycle if no stall).
- Slave `done` one enabled cycle after start: `out_valid` rises the following cycle with `out_cycles = 1`.
- Throughput: one op per (latency + 3) cycles with `out_ready` held high. `in_ready` is not asserted in HOLD (no overlap).
- `in_valid` without `in_ready` is not consumed; operands need not be held stable once accepted.

## Test plan
- Reset, then feed `dataa = 32'h40A00000`, `datab = 32'h41200000` to an FP-add slave model (done 3 cycles after start). Required: `ci_start` for one cycle after accept; `out_result = 32'h41700000`; `out_cycles = 3`; `op_count = 1`.
- Back-to-back 4 pairs with `out_ready` tied high. Required: 4 results in order, `in_ready` low from accept to HOLD exit, `op_count = 4`.
- `stall` high for 5 cycles during ISSUE and during WAIT. Required: `ci_start` held through stall, `out_cycles` excludes stalled cycles, result correct.
- Slave never asserts done, `TIMEOUT_CYCLES = 8`. Required: `out_result = 32'h7FC00000`, `out_cycles = 8`, `timeout_err` = 1 and sticky, `op_count` unchanged.
- `out_ready` low 6 cycles in HOLD plus spurious `ci_done` pulse. Required: `out_result` stable, no new accept, no count change.
- Reset asserted in WAIT, slave done arrives after. Required: all outputs at reset values, done ignored, next op works normally.
